// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler
//   Transmit-side frame sequencer and round-robin arbiter for the Ethernet TX
//   byte lane. Each frame is sent as preamble, SFD, the granted source's payload,
//   zero padding up to MIN_PAYLOAD, four FCS bytes, then an inter-frame gap.
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   arp_req/data/last       ARP frame builder byte source
//   udp_req/data/last       UDP frame builder byte source
//   fcs_data, fcs_tx_done   FCS generator byte and its 4th-byte strobe
//   arp_grant, udp_grant    consume one byte from the source this cycle
//   preamble_sfd_tx_done    pulse during the SFD cycle (FCS start)
//   arp/udp_data_done       pulse on the final payload/pad byte of a frame
//   fcs_data_in             payload/pad bytes fed to the FCS generator, else 0
//   tx_data, tx_en          byte lane to the MAC
//   err_fcs_timeout         pulse when fcs_tx_done never arrives
//   err_oversize            pulse when a frame is truncated at MAX_PAYLOAD
module eth_tx_scheduler #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_PAYLOAD  = 60,
    parameter int unsigned MAX_PAYLOAD  = 1514,
    parameter int unsigned IFG_LEN      = 12,
    parameter int unsigned FCS_TIMEOUT  = 8
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       arp_req,
    input  logic [7:0] arp_data,
    input  logic       arp_last,
    input  logic       udp_req,
    input  logic [7:0] udp_data,
    input  logic       udp_last,
    input  logic [7:0] fcs_data,
    input  logic       fcs_tx_done,
    output logic       arp_grant,
    output logic       udp_grant,
    output logic       preamble_sfd_tx_done,
    output logic       arp_data_done,
    output logic       udp_data_done,
    output logic [7:0] fcs_data_in,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       err_fcs_timeout,
    output logic       err_oversize
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG} state_e;

    localparam logic [3:0]  PRE_CNT = 4'(PREAMBLE_LEN);
    localparam logic [3:0]  IFG_CNT = 4'(IFG_LEN);
    localparam logic [3:0]  TO_CNT  = 4'(FCS_TIMEOUT);
    localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);

    state_e      state, state_nxt;
    logic        sel, sel_nxt;          // 0 = ARP, 1 = UDP
    logic        rr_prio, rr_prio_nxt;  // source that wins the next tie
    logic [10:0] byte_cnt, byte_cnt_nxt;
    logic [3:0]  gen_cnt, gen_cnt_nxt;

    logic [10:0] cnt_inc;
    logic [3:0]  gen_inc;
    logic [7:0]  src_data;
    logic        src_last;
    logic        data_done;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            sel      <= 1'b0;
            rr_prio  <= 1'b0;
            byte_cnt <= '0;
            gen_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_prio  <= rr_prio_nxt;
            byte_cnt <= byte_cnt_nxt;
            gen_cnt  <= gen_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        sel_nxt              = sel;
        rr_prio_nxt          = rr_prio;
        byte_cnt_nxt         = byte_cnt;
        gen_cnt_nxt          = gen_cnt;
        cnt_inc              = byte_cnt + 11'd1;
        gen_inc              = gen_cnt + 4'd1;
        src_data             = sel ? udp_data : arp_data;
        src_last             = sel ? udp_last : arp_last;
        data_done            = 1'b0;
        arp_grant            = 1'b0;
        udp_grant            = 1'b0;
        preamble_sfd_tx_done = 1'b0;
        fcs_data_in          = '0;
        tx_data              = '0;
        tx_en                = 1'b0;
        err_fcs_timeout      = 1'b0;
        err_oversize         = 1'b0;

        unique case (state)
            IDLE: begin
                gen_cnt_nxt = '0;
                if (arp_req || udp_req) begin
                    // Ties go to rr_prio, which then flips; a lone requester
                    // is served without disturbing the tie-break order.
                    if (arp_req && udp_req) begin
                        sel_nxt     = rr_prio;
                        rr_prio_nxt = ~rr_prio;
                    end else begin
                        sel_nxt = udp_req;
                    end
                    state_nxt = PREAMBLE;
                end
            end
            PREAMBLE: begin
                tx_en       = 1'b1;
                tx_data     = 8'h55;
                gen_cnt_nxt = gen_inc;
                if (gen_inc == PRE_CNT) begin
                    gen_cnt_nxt = '0;
                    state_nxt   = SFD;
                end
            end
            SFD: begin
                tx_en                = 1'b1;
                tx_data              = 8'hD5;
                preamble_sfd_tx_done = 1'b1;
                byte_cnt_nxt         = '0;
                state_nxt            = PAYLOAD;
            end
            PAYLOAD: begin
                tx_en        = 1'b1;
                tx_data      = src_data;
                fcs_data_in  = src_data;
                arp_grant    = ~sel;
                udp_grant    = sel;
                byte_cnt_nxt = cnt_inc;
                gen_cnt_nxt  = '0;
                // last wins over the size limit so a frame ending exactly at
                // MAX_PAYLOAD is a normal end rather than a truncation.
                if (src_last) begin
                    if (cnt_inc >= MIN_CNT) begin
                        data_done = 1'b1;
                        state_nxt = FCS;
                    end else begin
                        state_nxt = PAD;
                    end
                end else if (cnt_inc == MAX_CNT) begin
                    data_done    = 1'b1;
                    err_oversize = 1'b1;
                    state_nxt    = FCS;
                end
            end
            PAD: begin
                tx_en        = 1'b1;
                byte_cnt_nxt = cnt_inc;
                gen_cnt_nxt  = '0;
                if (cnt_inc >= MIN_CNT) begin
                    data_done = 1'b1;
                    state_nxt = FCS;
                end
            end
            FCS: begin
                tx_en       = 1'b1;
                tx_data     = fcs_data;
                gen_cnt_nxt = gen_inc;
                if (fcs_tx_done) begin
                    gen_cnt_nxt = '0;
                    state_nxt   = IFG;
                end else if (gen_inc == TO_CNT) begin
                    err_fcs_timeout = 1'b1;
                    gen_cnt_nxt     = '0;
                    state_nxt       = IFG;
                end
            end
            IFG: begin
                gen_cnt_nxt = gen_inc;
                if (gen_inc == IFG_CNT) begin
                    gen_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        arp_data_done = data_done & ~sel;
        udp_data_done = data_done & sel;
    end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb_eth_tx_scheduler
//   Scoreboard bench for eth_tx_scheduler. Each issued frame is expanded by a
//   frame-level model into the exact per-cycle byte/strobe sequence expected while
//   tx_en is high; a monitor pops and compares whenever tx_en is high and checks
//   that every output is quiet otherwise. A behavioural CRC-32 FCS generator and
//   two byte sources drive the inputs.
module tb_eth_tx_scheduler;

    localparam int PRE  = 7;
    localparam int MINP = 60;
    localparam int MAXP = 1514;
    localparam int IFGL = 12;
    localparam int TO   = 8;
    localparam int BIG  = 1000000;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       arp_req, arp_last, udp_req, udp_last, fcs_tx_done;
    logic [7:0] arp_data, udp_data, fcs_data;
    logic       arp_grant, udp_grant, preamble_sfd_tx_done;
    logic       arp_data_done, udp_data_done, tx_en;
    logic       err_fcs_timeout, err_oversize;
    logic [7:0] fcs_data_in, tx_data;

    always #5 aclk = ~aclk;

    eth_tx_scheduler #(
        .PREAMBLE_LEN(PRE), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP),
        .IFG_LEN(IFGL), .FCS_TIMEOUT(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arp_req(arp_req), .arp_data(arp_data), .arp_last(arp_last),
        .udp_req(udp_req), .udp_data(udp_data), .udp_last(udp_last),
        .fcs_data(fcs_data), .fcs_tx_done(fcs_tx_done),
        .arp_grant(arp_grant), .udp_grant(udp_grant),
        .preamble_sfd_tx_done(preamble_sfd_tx_done),
        .arp_data_done(arp_data_done), .udp_data_done(udp_data_done),
        .fcs_data_in(fcs_data_in), .tx_data(tx_data), .tx_en(tx_en),
        .err_fcs_timeout(err_fcs_timeout), .err_oversize(err_oversize)
    );

    typedef struct {
        int unsigned seed;
        int          len;
        bit          has_last;
    } frame_t;

    typedef struct {
        logic [22:0] v;
        int          gap_min;
        int          gap_max;
        int          fid;
        int          idx;
    } exp_t;

    exp_t   sb[$];
    frame_t apend[$];
    frame_t upend[$];
    frame_t cur[2];
    bit     active[2];
    bit     granted[2];
    int     idx[2];
    bit     fcs_stuck = 1'b0;
    int     checks = 0;
    int     failures = 0;
    int     fid = 0;

    function automatic logic [7:0] pay_byte(input int unsigned seed, input int i);
        int unsigned h;
        h = (seed + 32'(i)) * 32'h9E3779B1;
        return h[31:24] ^ h[15:8];
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // {tx_data, fcs_data_in, sfd, arp_done, udp_done, arp_grant, udp_grant, ovs, timeout}
    function automatic logic [22:0] pk(input logic [7:0] d, input logic [7:0] f, input bit sfd,
                                       input bit ad, input bit ud, input bit ag, input bit ug,
                                       input bit ov, input bit tmo);
        return {d, f, sfd, ad, ud, ag, ug, ov, tmo};
    endfunction

    function automatic logic [22:0] observed();
        return pk(tx_data, fcs_data_in, preamble_sfd_tx_done, arp_data_done, udp_data_done,
                  arp_grant, udp_grant, err_oversize, err_fcs_timeout);
    endfunction

    // Frame-level model: expands one frame into its tx_en-high cycle sequence.
    task automatic build_frame(input int src, input frame_t fr, input bit stuck,
                               input int gmin, input int gmax);
        exp_t        e;
        int          n, tot, k;
        bit          trunc, lastb, isp;
        logic [31:0] crc;
        logic [7:0]  b;
        n = fr.len;
        trunc = 1'b0;
        if (!fr.has_last || fr.len > MAXP) begin
            n = MAXP;
            trunc = 1'b1;
        end
        tot = (n < MINP) ? MINP : n;
        fid++;
        e.fid = fid; e.gap_min = gmin; e.gap_max = gmax;
        k = 0;
        for (int i = 0; i < PRE; i++) begin
            e.idx = k++; e.v = pk(8'h55, 8'h00, 0, 0, 0, 0, 0, 0, 0); sb.push_back(e);
        end
        e.idx = k++; e.v = pk(8'hD5, 8'h00, 1, 0, 0, 0, 0, 0, 0); sb.push_back(e);
        crc = '1;
        for (int i = 0; i < tot; i++) begin
            isp   = (i < n);
            b     = isp ? pay_byte(fr.seed, i) : 8'h00;
            crc   = crc_upd(crc, b);
            lastb = (i == tot - 1);
            e.idx = k++;
            e.v = pk(b, b, 0, lastb && src == 0, lastb && src == 1, isp && src == 0,
                     isp && src == 1, lastb && trunc, 0);
            sb.push_back(e);
        end
        crc = ~crc;
        for (int j = 0; j < (stuck ? TO : 4); j++) begin
            b = (j < 4) ? crc[8*j +: 8] : 8'h00;
            e.idx = k++;
            e.v = pk(b, 8'h00, 0, 0, 0, 0, 0, 0, stuck && j == TO - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send(input int src, input int len, input bit has_last, input bit stuck,
                        input int gmin, input int gmax, output frame_t fr);
        fr.seed = $urandom;
        fr.len = len;
        fr.has_last = has_last;
        build_frame(src, fr, stuck, gmin, gmax);
        if (src == 0) apend.push_back(fr); else upend.push_back(fr);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || active[0] || active[1] || apend.size() != 0 ||
                upend.size() != 0) && c < budget) begin
            @(negedge aclk);
            c++;
        end
        checks++;
        if (c >= budget) begin
            failures++;
            $display("FAIL drain_timeout expected_left=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (IFGL + 2) @(negedge aclk);
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [22:0] got;
        int          idle;
        idle = BIG;
        forever begin
            @(negedge aclk);
            got = observed();
            if (tx_en) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tx got=%h required=no_transmission", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.v) begin
                        failures++;
                        $display("FAIL frame%0d_cycle%0d got=%h required=%h", e.fid, e.idx, got, e.v);
                    end
                    if (e.idx == 0) begin
                        checks++;
                        if (idle < e.gap_min || idle > e.gap_max) begin
                            failures++;
                            $display("FAIL frame%0d_gap got=%0d required=%0d..%0d",
                                     e.fid, idle, e.gap_min, e.gap_max);
                        end
                    end
                end
                idle = 0;
            end else begin
                checks++;
                if (got !== '0) begin
                    failures++;
                    $display("FAIL idle_outputs got=%h required=0", got);
                end
                if (idle < BIG) idle++;
            end
        end
    end

    // Byte sources: hold req until the first grant, present byte idx, advance on grant.
    initial begin
        bit took[2];
        arp_req = 0; arp_data = '0; arp_last = 0;
        udp_req = 0; udp_data = '0; udp_last = 0;
        for (int s = 0; s < 2; s++) begin active[s] = 0; granted[s] = 0; idx[s] = 0; end
        forever begin
            @(negedge aclk);
            took[0] = arp_grant;
            took[1] = udp_grant;
            @(posedge aclk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (!aresetn) begin
                    if (granted[s]) begin active[s] = 0; granted[s] = 0; end
                end else if (active[s]) begin
                    if (took[s]) begin
                        granted[s] = 1;
                        if (cur[s].has_last && idx[s] == cur[s].len - 1) begin
                            active[s] = 0; granted[s] = 0;
                        end else begin
                            idx[s]++;
                        end
                    end else if (granted[s]) begin
                        active[s] = 0; granted[s] = 0;  // grant withdrawn: frame truncated
                    end
                end
                if (!active[s]) begin
                    if (s == 0 && apend.size() != 0) begin cur[0] = apend.pop_front(); active[0] = 1; end
                    if (s == 1 && upend.size() != 0) begin cur[1] = upend.pop_front(); active[1] = 1; end
                    idx[s] = 0; granted[s] = 0;
                end
            end
            arp_req  = active[0] && !granted[0];
            arp_data = active[0] ? pay_byte(cur[0].seed, idx[0]) : 8'h00;
            arp_last = active[0] && cur[0].has_last && idx[0] == cur[0].len - 1;
            udp_req  = active[1] && !granted[1];
            udp_data = active[1] ? pay_byte(cur[1].seed, idx[1]) : 8'h00;
            udp_last = active[1] && cur[1].has_last && idx[1] == cur[1].len - 1;
        end
    end

    // FCS generator: CRC-32 from SFD strobe through the data_done byte, then 4 bytes LSB first.
    initial begin
        logic [31:0] crc, word;
        bit          collecting, start_out;
        int          out_k;
        crc = '1; word = '0; collecting = 0; out_k = -1;
        fcs_data = '0; fcs_tx_done = 0;
        forever begin
            @(negedge aclk);
            start_out = 0;
            if (!aresetn) begin
                collecting = 0; out_k = -1;
            end else begin
                if (collecting) begin
                    crc = crc_upd(crc, fcs_data_in);
                    if (arp_data_done || udp_data_done) begin collecting = 0; start_out = 1; end
                end
                if (preamble_sfd_tx_done) begin collecting = 1; crc = '1; end
            end
            @(posedge aclk);
            #1;
            if (!aresetn) out_k = -1;
            else if (start_out) begin word = ~crc; out_k = 0; end
            else if (out_k >= 0) out_k = (out_k >= TO - 1) ? -1 : out_k + 1;
            fcs_data    = (out_k >= 0 && out_k < 4) ? word[8*out_k +: 8] : 8'h00;
            fcs_tx_done = (out_k == 3) && !fcs_stuck;
        end
    end

    // Stimulus
    initial begin
        frame_t fr, ufr;
        bit     found;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({tx_en, observed()} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {tx_en, observed()});
        end
        aresetn = 1'b1;

        send(0, 42, 1, 0, 0, BIG, fr);            // ARP 42 -> 18 pad bytes
        drain(2000);
        send(1, 100, 1, 0, IFGL + 1, BIG, fr);    // UDP 100 -> no padding
        drain(2000);

        // Both requesting from reset: A, U, A, U with minimum gaps.
        @(negedge aclk);
        aresetn = 1'b0;
        send(0, $urandom_range(20, 90), 1, 0, 0, BIG, fr);
        send(1, $urandom_range(20, 90), 1, 0, IFGL + 1, IFGL + 1, fr);
        send(0, $urandom_range(20, 90), 1, 0, IFGL + 1, IFGL + 1, fr);
        send(1, $urandom_range(20, 90), 1, 0, IFGL + 1, IFGL + 1, fr);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        drain(4000);

        send(1, 2000, 0, 0, IFGL + 1, BIG, fr);   // no last -> truncation at MAXP
        drain(3000);

        fcs_stuck = 1'b1;
        send(0, 30, 1, 1, IFGL + 1, BIG, fr);     // FCS timeout
        drain(2000);
        fcs_stuck = 1'b0;
        send(1, 70, 1, 0, IFGL + 1, BIG, fr);
        drain(2000);

        send(0, MINP, 1, 0, IFGL + 1, BIG, fr);     drain(2000);
        send(1, MINP - 1, 1, 0, IFGL + 1, BIG, fr); drain(2000);
        send(0, 1, 1, 0, IFGL + 1, BIG, fr);        drain(2000);
        send(1, MAXP, 1, 0, IFGL + 1, BIG, fr);     drain(3000);

        for (int r = 0; r < 8; r++) begin
            send(int'($urandom_range(0, 1)), int'($urandom_range(1, 150)), 1, 0, IFGL + 1, BIG, fr);
            drain(2000);
        end

        // Reset mid-payload: ARP wins the tie first, then reset must restore ARP priority.
        @(negedge aclk);
        aresetn = 1'b0;
        send(0, 80, 1, 0, 0, BIG, fr);
        send(1, 50, 1, 0, IFGL + 1, IFGL + 1, ufr);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge aclk);
            if (arp_grant && idx[0] == 19) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_byte20 got=not_seen required=seen");
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({tx_en, observed()} !== '0) begin
            failures++;
            $display("FAIL async_reset_drop got=%h required=0", {tx_en, observed()});
        end
        sb.delete();
        send(0, int'($urandom_range(20, 90)), 1, 0, 0, BIG, fr);
        build_frame(1, ufr, 0, IFGL + 1, IFGL + 1);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
